// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline registers: load-use, divide, SRAM wait and exceptions.
// Optional performance counters are compiled in when PIPE_PERF_CNT_EN is defined.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_write_dst,
  input  logic       ex_div_start,
  input  logic       mem_req,
  input  logic       mem_data_ok,
  input  logic       exc_valid,
  output logic       stall_if,
  output logic       stall_id,
  output logic       stall_ex,
  output logic       stall_mem,
  output logic       flush_id,
  output logic       flush_ex,
  output logic       flush_mem,
  output logic       flush_wb,
  output logic       redirect,
  output logic       div_busy,
  output logic [1:0] state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flush_events
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_BUSY = 2'd2,
    EXC      = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             load_use_s;
  logic             stall_if_s, stall_id_s, stall_ex_s, stall_mem_s;
  logic             flush_id_s, flush_ex_s, flush_mem_s, flush_wb_s;
  logic             redirect_s, div_busy_s;

  // Register $0 is hard-wired zero, so a load targeting it never creates a dependency.
  always_comb begin
    load_use_s = ex_mem_read & (ex_write_dst != 5'd0) &
                 ((id_uses_rs & (id_rs == ex_write_dst)) |
                  (id_uses_rt & (id_rt == ex_write_dst)));
  end

  // Next-state, divide countdown and raw stall/flush decode
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    stall_if_s  = 1'b0;
    stall_id_s  = 1'b0;
    stall_ex_s  = 1'b0;
    stall_mem_s = 1'b0;
    flush_id_s  = 1'b0;
    flush_ex_s  = 1'b0;
    flush_mem_s = 1'b0;
    flush_wb_s  = 1'b0;
    redirect_s  = 1'b0;
    div_busy_s  = 1'b0;
    case (state_q)
      RUN: begin
        if (exc_valid) begin
          flush_id_s  = 1'b1;
          flush_ex_s  = 1'b1;
          flush_mem_s = 1'b1;
          flush_wb_s  = 1'b1;
          state_d     = EXC;
        end else if (mem_req && !mem_data_ok) begin
          stall_if_s  = 1'b1;
          stall_id_s  = 1'b1;
          stall_ex_s  = 1'b1;
          stall_mem_s = 1'b1;
          flush_wb_s  = 1'b1;
          state_d     = MEM_WAIT;
        end else if (ex_div_start) begin
          stall_if_s  = 1'b1;
          stall_id_s  = 1'b1;
          stall_ex_s  = 1'b1;
          flush_mem_s = 1'b1;
          div_busy_s  = 1'b1;
          cnt_d       = CNT_W'(DIV_CYCLES - 2);
          state_d     = DIV_BUSY;
        end else if (load_use_s) begin
          stall_if_s = 1'b1;
          stall_id_s = 1'b1;
          flush_ex_s = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        // The outstanding access always completes; exceptions wait until RUN.
        if (!mem_data_ok) begin
          stall_if_s  = 1'b1;
          stall_id_s  = 1'b1;
          stall_ex_s  = 1'b1;
          stall_mem_s = 1'b1;
          flush_wb_s  = 1'b1;
        end else begin
          state_d = RUN;
        end
      end
      DIV_BUSY: begin
        div_busy_s = 1'b1;
        if (exc_valid) begin
          flush_id_s  = 1'b1;
          flush_ex_s  = 1'b1;
          flush_mem_s = 1'b1;
          flush_wb_s  = 1'b1;
          cnt_d       = {CNT_W{1'b0}};
          state_d     = EXC;
        end else if (cnt_q == {CNT_W{1'b0}}) begin
          state_d = RUN;
        end else begin
          stall_if_s  = 1'b1;
          stall_id_s  = 1'b1;
          stall_ex_s  = 1'b1;
          flush_mem_s = 1'b1;
          cnt_d       = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      EXC: begin
        redirect_s = 1'b1;
        flush_id_s = 1'b1;
        state_d    = RUN;
      end
      default: begin
        state_d = RUN;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
  end

  // State and countdown registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Controls are combinational but must stay quiet while reset is asserted.
  always_comb begin
    stall_if  = rst_n & stall_if_s;
    stall_id  = rst_n & stall_id_s;
    stall_ex  = rst_n & stall_ex_s;
    stall_mem = rst_n & stall_mem_s;
    flush_id  = rst_n & flush_id_s;
    flush_ex  = rst_n & flush_ex_s;
    flush_mem = rst_n & flush_mem_s;
    flush_wb  = rst_n & flush_wb_s;
    redirect  = rst_n & redirect_s;
    div_busy  = rst_n & div_busy_s;
    state     = state_q;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Saturating stall-cycle and exception-entry counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 32'd0;
    end else begin
      if (stall_if && (perf_stall_q != 32'hFFFF_FFFF)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
      if ((state_d == EXC) && (state_q != EXC) && (perf_flush_q != 32'hFFFF_FFFF)) begin
        perf_flush_q <= perf_flush_q + 32'd1;
      end
    end
  end

  always_comb begin
    perf_stall_cycles = perf_stall_q;
    perf_flush_events = perf_flush_q;
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed vector table, multi-cycle sequences
// and a randomized run against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
  localparam int DIV_CYCLES = 33;

  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       urs;
    logic       urt;
    logic       rd;
    logic [4:0] dst;
    logic       div;
    logic       req;
    logic       ok;
    logic       exc;
  } vin_t;

  typedef struct packed {
    vin_t       in;
    logic [9:0] o;   // {sif,sid,sex,smem,fid,fex,fmem,fwb,redirect,div_busy}
    logic [1:0] st;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [4:0] id_rs, id_rt, ex_write_dst;
  logic id_uses_rs, id_uses_rt, ex_mem_read, ex_div_start, mem_req, mem_data_ok, exc_valid;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem, flush_wb;
  logic redirect, div_busy;
  logic [1:0] state;
  logic [9:0] dut_o;
`ifdef PIPE_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_flush_events;
`endif

  pipe_hazard_ctrl #(.DIV_CYCLES(DIV_CYCLES), .CNT_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .ex_mem_read(ex_mem_read),
    .ex_write_dst(ex_write_dst), .ex_div_start(ex_div_start), .mem_req(mem_req),
    .mem_data_ok(mem_data_ok), .exc_valid(exc_valid),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem), .flush_wb(flush_wb),
    .redirect(redirect), .div_busy(div_busy), .state(state)
`ifdef PIPE_PERF_CNT_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events)
`endif
  );

  assign dut_o = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex,
                  flush_mem, flush_wb, redirect, div_busy};

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: what the pipeline is currently doing, in plain terms
  bit m_exc_pending;   // redirect cycle owed
  bit m_waiting;       // SRAM access outstanding
  int m_div_left;      // EX-occupancy cycles still owed to the divide
  int m_stalls, m_exc_entries;
  bit n_exc_pending, n_waiting;
  int n_div_left;
  logic [9:0] last_o;
  logic [1:0] last_st;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_exc_pending = 1'b0; m_waiting = 1'b0; m_div_left = 0;
    m_stalls = 0; m_exc_entries = 0;
  endtask

  task automatic model_eval(input vin_t v, output logic [9:0] o, output logic [1:0] st);
    bit lu;
    lu = v.rd && (v.dst != 5'd0) && ((v.urs && v.rs == v.dst) || (v.urt && v.rt == v.dst));
    o = 10'd0;
    n_exc_pending = 1'b0; n_waiting = m_waiting; n_div_left = m_div_left;
    if (m_exc_pending) begin
      st = 2'd3; o = 10'b0000_1000_10;
    end else if (m_waiting) begin
      st = 2'd1;
      if (!v.ok) o = 10'b1111_0001_00;
      else n_waiting = 1'b0;
    end else if (m_div_left > 0) begin
      st = 2'd2;
      if (v.exc) begin
        o = 10'b0000_1111_01; n_div_left = 0; n_exc_pending = 1'b1;
      end else if (m_div_left == 1) begin
        o = 10'b0000_0000_01; n_div_left = 0;
      end else begin
        o = 10'b1110_0010_01; n_div_left = m_div_left - 1;
      end
    end else begin
      st = 2'd0;
      if (v.exc) begin
        o = 10'b0000_1111_00; n_exc_pending = 1'b1;
      end else if (v.req && !v.ok) begin
        o = 10'b1111_0001_00; n_waiting = 1'b1;
      end else if (v.div) begin
        o = 10'b1110_0010_01; n_div_left = DIV_CYCLES - 1;
      end else if (lu) begin
        o = 10'b1100_0100_00;
      end
    end
  endtask

  task automatic drive(input vin_t v);
    id_rs = v.rs; id_rt = v.rt; id_uses_rs = v.urs; id_uses_rt = v.urt;
    ex_mem_read = v.rd; ex_write_dst = v.dst; ex_div_start = v.div;
    mem_req = v.req; mem_data_ok = v.ok; exc_valid = v.exc;
  endtask

  // One clock cycle: drive, sample mid-cycle against the model, then advance
  task automatic apply(input vin_t v);
    logic [9:0] eo;
    logic [1:0] est;
    drive(v);
    #2;
    model_eval(v, eo, est);
    check("outputs", {22'd0, dut_o}, {22'd0, eo});
    check("state", {30'd0, state}, {30'd0, est});
    last_o = dut_o; last_st = state;
    @(posedge clk);
    if (eo[9]) m_stalls++;
    if (n_exc_pending) m_exc_entries++;
    m_exc_pending = n_exc_pending; m_waiting = n_waiting; m_div_left = n_div_left;
    #1;
  endtask

  function automatic vin_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                              input logic urt, input logic rd, input logic [4:0] dst,
                              input logic div, input logic req, input logic ok, input logic exc);
    vin_t v;
    v.rs = rs; v.rt = rt; v.urs = urs; v.urt = urt; v.rd = rd; v.dst = dst;
    v.div = div; v.req = req; v.ok = ok; v.exc = exc;
    return v;
  endfunction

  vec_t tbl[18];
  vin_t idle, v;
  int busy_cnt, stall_cnt, back_at;

  initial begin
    idle = mk(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[0]  = '{mk(5'd8, 5'd0, 1, 0, 1, 5'd8, 0, 0, 0, 0), 10'b1100_0100_00, 2'd0};
    tbl[1]  = '{idle,                                      10'b0000_0000_00, 2'd0};
    tbl[2]  = '{mk(5'd0, 5'd0, 1, 0, 1, 5'd0, 0, 0, 0, 0), 10'b0000_0000_00, 2'd0};
    tbl[3]  = '{mk(5'd1, 5'd9, 0, 1, 1, 5'd9, 0, 0, 0, 0), 10'b1100_0100_00, 2'd0};
    tbl[4]  = '{mk(5'd9, 5'd3, 0, 1, 1, 5'd9, 0, 0, 0, 0), 10'b0000_0000_00, 2'd0};
    tbl[5]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0), 10'b0000_0000_00, 2'd0};
    tbl[6]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0), 10'b1111_0001_00, 2'd0};
    tbl[7]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0), 10'b1111_0001_00, 2'd1};
    tbl[8]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 1), 10'b1111_0001_00, 2'd1};
    tbl[9]  = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 1), 10'b0000_0000_00, 2'd1};
    tbl[10] = '{idle,                                      10'b0000_0000_00, 2'd0};
    tbl[11] = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1), 10'b0000_1111_00, 2'd0};
    tbl[12] = '{idle,                                      10'b0000_1000_10, 2'd3};
    tbl[13] = '{mk(5'd4, 5'd0, 1, 0, 1, 5'd4, 1, 1, 0, 1), 10'b0000_1111_00, 2'd0};
    tbl[14] = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1), 10'b0000_1000_10, 2'd3};
    tbl[15] = '{idle,                                      10'b0000_0000_00, 2'd0};
    tbl[16] = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0), 10'b1111_0001_00, 2'd0};
    tbl[17] = '{mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 1, 0), 10'b0000_0000_00, 2'd1};

    // Reset with hazards asserted: every control must stay low
    rst_n = 1'b0;
    drive(mk(5'd8, 5'd0, 1, 0, 1, 5'd8, 1, 1, 0, 1));
    model_reset();
    #3;
    check("reset_outputs", {22'd0, dut_o}, 32'd0);
    check("reset_state", {30'd0, state}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    check("reset_perf_stall", perf_stall_cycles, 32'd0);
    check("reset_perf_flush", perf_flush_events, 32'd0);
`endif
    @(posedge clk); @(posedge clk); #1;
    drive(idle);
    rst_n = 1'b1;

    for (int i = 0; i < 18; i++) begin
      apply(tbl[i].in);
      check($sformatf("tbl%0d_out", i), {22'd0, last_o}, {22'd0, tbl[i].o});
      check($sformatf("tbl%0d_state", i), {30'd0, last_st}, {30'd0, tbl[i].st});
    end
    apply(idle);

    // Divide: EX held DIV_CYCLES cycles, stalls release on the final one
    busy_cnt = 0; stall_cnt = 0; back_at = -1;
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0));
    busy_cnt += int'(last_o[0]); stall_cnt += int'(last_o[9]);
    for (int c = 1; c < 40; c++) begin
      apply(idle);
      busy_cnt += int'(last_o[0]); stall_cnt += int'(last_o[9]);
      if (back_at < 0 && last_st == 2'd0) back_at = c;
    end
    check("div_busy_cycles", busy_cnt, DIV_CYCLES);
    check("div_stall_cycles", stall_cnt, DIV_CYCLES - 1);
    check("div_return_cycle", back_at, DIV_CYCLES);

    // Exception on the 5th DIV_BUSY cycle aborts the divide
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 1, 0, 0, 0));
    for (int c = 0; c < 4; c++) apply(idle);
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 0, 0, 1));
    check("divexc_flushes", {28'd0, last_o[5:2]}, 32'hF);
    check("divexc_state", {30'd0, last_st}, 32'd2);
    apply(idle);
    check("divexc_redirect", {31'd0, last_o[1]}, 32'd1);
    check("divexc_busy_off", {31'd0, last_o[0]}, 32'd0);
    check("divexc_state_exc", {30'd0, last_st}, 32'd3);
    apply(idle);
    check("divexc_redirect_off", {31'd0, last_o[1]}, 32'd0);
    check("divexc_state_run", {30'd0, last_st}, 32'd0);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      v.rs = 5'($urandom_range(3, 0)); v.rt = 5'($urandom_range(3, 0));
      v.urs = 1'($urandom); v.urt = 1'($urandom); v.rd = 1'($urandom);
      v.dst = 5'($urandom_range(3, 0));
      v.div = ($urandom_range(24, 0) == 0);
      v.req = ($urandom_range(3, 0) == 0);
      v.ok  = 1'($urandom);
      v.exc = ($urandom_range(40, 0) == 0);
      apply(v);
    end
`ifdef PIPE_PERF_CNT_EN
    check("perf_stall", perf_stall_cycles, 32'(m_stalls));
    check("perf_flush", perf_flush_events, 32'(m_exc_entries));
`endif

    // Asynchronous reset in the middle of an SRAM wait
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0));
    apply(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0));
    check("wait_state_before_rst", {30'd0, last_st}, 32'd1);
    drive(mk(5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0));
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_outputs", {22'd0, dut_o}, 32'd0);
    check("midrst_state", {30'd0, state}, 32'd0);
`ifdef PIPE_PERF_CNT_EN
    check("midrst_perf_stall", perf_stall_cycles, 32'd0);
    check("midrst_perf_flush", perf_flush_events, 32'd0);
`endif
    @(posedge clk); #1;
    drive(idle);
    rst_n = 1'b1;
    model_reset();
    apply(mk(5'd8, 5'd0, 1, 0, 1, 5'd8, 0, 0, 0, 0));
    apply(idle);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
